// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch controller feeding if_stage.
// Keeps a single outstanding imem request and holds the returned word with its PC and PC+4.
// Branch/trap redirects flush the held word and any in-flight fetch.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        trap_i,
  input  logic [31:0] trap_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic [31:0] instruction_o,
  output logic        misaligned_o
);

  localparam logic [1:0]  S_REQ  = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_DROP = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [1:0]  r_state,    w_state_d;
  logic [31:0] r_fetch_pc, w_fetch_pc_d;
  logic        r_valid,    w_valid_d;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus_4;
  logic [31:0] r_instr;
  logic        r_misaligned;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic        w_req;
  logic        w_load;

  // Redirect decode: trap outranks branch; target is word-aligned by dropping bits [1:0].
  always_comb begin
    w_redirect   = trap_i | branch_taken_i;
    w_target_raw = trap_i ? trap_target_i : branch_target_i;
    w_target     = {w_target_raw[31:2], 2'b00};
    // Only fetch when the output slot will be free, so a returning word never finds it occupied.
    w_req        = (r_state == S_REQ) && !w_redirect && (!r_valid || !stall_i);
    w_load       = (r_state == S_WAIT) && imem_rvalid_i && !w_redirect;
  end

  // Next fetch state and fetch PC.
  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    case (r_state)
      S_REQ: begin
        if (w_redirect) begin
          w_fetch_pc_d = w_target;
        end else if (w_req && imem_gnt_i) begin
          w_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_fetch_pc_d = w_target;
          // Stale word still owed by memory unless it returns this very cycle.
          w_state_d    = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          w_fetch_pc_d = r_fetch_pc + 32'd4;
          w_state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (w_redirect) begin
          w_fetch_pc_d = w_target;
        end
        if (imem_rvalid_i) begin
          w_state_d = S_REQ;
        end
      end
      default: w_state_d = S_REQ;
    endcase
  end

  // Output-slot occupancy: flush beats stall, reload beats consumption.
  always_comb begin
    w_valid_d = r_valid;
    if (w_redirect) begin
      w_valid_d = 1'b0;
    end else if (w_load) begin
      w_valid_d = 1'b1;
    end else if (r_valid && !stall_i) begin
      w_valid_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_fetch_pc   <= RESET_PC;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_fetch_pc   <= w_fetch_pc_d;
      r_valid      <= w_valid_d;
      r_misaligned <= w_redirect && (w_target_raw[1:0] != 2'b00);
    end
  end

  // Output data register, loaded when a live word returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= 32'h0000_0000;
      r_pc_plus_4 <= 32'h0000_0000;
      r_instr     <= NOP;
    end else if (w_load) begin
      r_pc        <= r_fetch_pc;
      r_pc_plus_4 <= r_fetch_pc + 32'd4;
      r_instr     <= imem_rdata_i;
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign valid_o       = r_valid;
  assign pc_o          = r_pc;
  assign pc_plus_4_o   = r_pc_plus_4;
  assign instruction_o = r_instr;
  assign misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: memory responder, scoreboard of fetched words,
// directed scenarios followed by a randomised stall/redirect/latency phase.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        trap_i;
  logic [31:0] trap_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;
  logic [31:0] instruction_o;
  logic        misaligned_o;

  // Second instance exercising the address wrap from RESET_PC = 0xFFFF_FFFC.
  logic        w2_req;
  logic [31:0] w2_addr;
  logic        w2_rvalid;
  logic [31:0] w2_rdata;
  logic        w2_valid;
  logic [31:0] w2_pc;
  logic [31:0] w2_pc4;
  logic [31:0] w2_instr;
  logic        w2_mis;
  logic        zero_b;
  logic [31:0] zero_w;

  pc_fetch_unit u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .trap_target_i   (trap_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .valid_o         (valid_o),
    .pc_o            (pc_o),
    .pc_plus_4_o     (pc_plus_4_o),
    .instruction_o   (instruction_o),
    .misaligned_o    (misaligned_o)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (zero_b),
    .branch_taken_i  (zero_b),
    .branch_target_i (zero_w),
    .trap_i          (zero_b),
    .trap_target_i   (zero_w),
    .imem_req_o      (w2_req),
    .imem_addr_o     (w2_addr),
    .imem_gnt_i      (1'b1),
    .imem_rvalid_i   (w2_rvalid),
    .imem_rdata_i    (w2_rdata),
    .valid_o         (w2_valid),
    .pc_o            (w2_pc),
    .pc_plus_4_o     (w2_pc4),
    .instruction_o   (w2_instr),
    .misaligned_o    (w2_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_consumed = 0;

  logic [63:0] sb_q[$];
  logic [31:0] exp_addr;
  logic        mis_exp;
  int          lat;
  int          rv_cnt;
  logic [31:0] rv_data;
  logic        rand_mode;
  logic        g2;
  logic [31:0] a2;
  logic        prev_req_pending;
  logic [31:0] prev_req_addr;

  // Values sampled in the last cycle, for directed checks.
  logic        s_req, s_valid, s_mis, s_req2, s_valid2;
  logic [31:0] s_addr, s_pc, s_addr2, s_pc2, s_pc4_2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  // One clock cycle: entered and left at posedge+1; outputs sampled at the negedge.
  task automatic run_cycle(input logic st, input logic br, input logic [31:0] bt,
                           input logic tr, input logic [31:0] tt);
    logic        redir;
    logic [31:0] raw;
    logic [63:0] ent;
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = bt;
    trap_i          = tr;
    trap_target_i   = tt;
    imem_gnt_i      = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_rvalid_i   = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = rv_data;
      end
    end
    w2_rvalid = g2;
    w2_rdata  = mem_word(a2);
    #4;
    s_req    = imem_req_o;
    s_addr   = imem_addr_o;
    s_valid  = valid_o;
    s_pc     = pc_o;
    s_mis    = misaligned_o;
    s_req2   = w2_req;
    s_addr2  = w2_addr;
    s_valid2 = w2_valid;
    s_pc2    = w2_pc;
    s_pc4_2  = w2_pc4;
    check_eq("misaligned", misaligned_o, mis_exp);
    redir = tr | br;
    raw   = tr ? tt : bt;
    if (redir) check_eq("req_on_redirect", imem_req_o, 0);
    if (prev_req_pending && !redir) begin
      check_eq("req_hold", imem_req_o, 1);
      check_eq("req_hold_addr", imem_addr_o, prev_req_addr);
    end
    if (valid_o && !st && !redir) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'(sb_q.size()), 1);
      end else begin
        ent = sb_q.pop_front();
        check_eq("pc_o", pc_o, ent[63:32]);
        check_eq("pc_plus_4_o", pc_plus_4_o, ent[63:32] + 32'd4);
        check_eq("instruction_o", instruction_o, ent[31:0]);
        n_consumed++;
      end
    end
    if (redir) begin
      sb_q.delete();
      exp_addr = {raw[31:2], 2'b00};
      mis_exp  = (raw[1:0] != 2'b00);
    end else begin
      mis_exp = 1'b0;
    end
    prev_req_pending = imem_req_o && !imem_gnt_i;
    prev_req_addr    = imem_addr_o;
    if (imem_req_o && imem_gnt_i) begin
      check_eq("req_addr", imem_addr_o, exp_addr);
      sb_q.push_back({exp_addr, mem_word(exp_addr)});
      exp_addr = exp_addr + 32'd4;
      rv_cnt   = lat;
      rv_data  = mem_word(imem_addr_o);
    end
    g2 = w2_req;
    a2 = w2_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r_st, r_br, r_tr;
    logic [31:0] r_bt, r_tt;
    zero_b = 1'b0;
    zero_w = 32'h0;
    rst_n = 1'b0;
    stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    trap_i = 1'b0; trap_target_i = 32'h0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    w2_rvalid = 1'b0; w2_rdata = 32'h0;
    exp_addr = 32'h0; mis_exp = 1'b0; lat = 1; rv_cnt = 0; rv_data = 32'h0;
    rand_mode = 1'b0; g2 = 1'b0; a2 = 32'h0;
    prev_req_pending = 1'b0; prev_req_addr = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_pc", pc_o, 0);
    check_eq("rst_pc4", pc_plus_4_o, 0);
    check_eq("rst_instr", instruction_o, 32'h0000_0013);
    check_eq("rst_mis", misaligned_o, 0);
    check_eq("rst_addr", imem_addr_o, 0);
    check_eq("rst_wrap_addr", w2_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Zero-wait streaming: one instruction every two cycles.
    idle_cycle();  // c0
    check_eq("c0_req", s_req, 1);
    check_eq("c0_addr", s_addr, 0);
    check_eq("wrap_c0_req", s_req2, 1);
    check_eq("wrap_c0_addr", s_addr2, 32'hFFFF_FFFC);
    idle_cycle();  // c1
    check_eq("c1_req", s_req, 0);
    idle_cycle();  // c2
    check_eq("c2_valid", s_valid, 1);
    check_eq("c2_req", s_req, 1);
    check_eq("c2_addr", s_addr, 32'h4);
    check_eq("wrap_valid", s_valid2, 1);
    check_eq("wrap_pc", s_pc2, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", s_pc4_2, 32'h0);
    check_eq("wrap_next_addr", s_addr2, 32'h0);
    repeat (3) idle_cycle();  // c3..c5

    // Stall with the word at 0x8 held.
    repeat (3) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check_eq("stall_valid", s_valid, 1);
      check_eq("stall_pc", s_pc, 32'h8);
      check_eq("stall_req", s_req, 0);
    end
    idle_cycle();  // c9
    check_eq("resume_req", s_req, 1);
    check_eq("resume_addr", s_addr, 32'hC);
    idle_cycle();  // c10
    lat = 3;
    idle_cycle();  // c11: fetch 0x10, data due three cycles later
    check_eq("c11_addr", s_addr, 32'h10);

    // Branch while waiting on 0x10.
    run_cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);  // c12
    idle_cycle();  // c13
    check_eq("br_valid", s_valid, 0);
    check_eq("br_drop_req", s_req, 0);
    lat = 1;
    idle_cycle();  // c14: stale word returns
    check_eq("br_stale_req", s_req, 0);
    idle_cycle();  // c15
    check_eq("br_new_req", s_req, 1);
    check_eq("br_new_addr", s_addr, 32'h100);
    idle_cycle();  // c16

    // Trap and branch together under stall: trap wins, flush beats stall.
    run_cycle(1'b1, 1'b1, 32'h300, 1'b1, 32'h200);  // c17
    run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);      // c18
    check_eq("trap_valid", s_valid, 0);
    check_eq("trap_req", s_req, 1);
    check_eq("trap_addr", s_addr, 32'h200);
    idle_cycle();  // c19
    idle_cycle();  // c20

    // Misaligned branch target while the 0x204 word returns.
    run_cycle(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);  // c21
    idle_cycle();  // c22
    check_eq("mis_pulse", s_mis, 1);
    check_eq("mis_valid", s_valid, 0);
    check_eq("mis_addr", s_addr, 32'h100);
    idle_cycle();  // c23
    check_eq("mis_clear", s_mis, 0);

    // Randomised stalls, grants, latencies and redirects.
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      lat  = int'($urandom_range(1, 3));
      r_st = ($urandom_range(0, 2) == 0);
      r_br = ($urandom_range(0, 9) == 0);
      r_tr = ($urandom_range(0, 19) == 0);
      r_bt = 32'h400 + 32'($urandom_range(0, 63));
      r_tt = 32'h800 + 32'($urandom_range(0, 63));
      run_cycle(r_st, r_br, r_bt, r_tr, r_tt);
    end
    rand_mode = 1'b0;
    lat = 1;
    repeat (8) idle_cycle();
    check_eq("consumed_enough", 32'(n_consumed >= 10), 1);

    // Asynchronous reset in mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", valid_o, 0);
    check_eq("arst_pc", pc_o, 0);
    check_eq("arst_instr", instruction_o, 32'h0000_0013);
    check_eq("arst_addr", imem_addr_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog in case the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch controller sitting directly upstream of `if_stage`. It owns the fetch PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and holds each returned instruction with its PC and PC+4 in an output register that drives `if_stage`'s `pc_i`, `pc_plus_4_i` and `instruction_i`. It also absorbs hazard-unit stalls and branch/trap redirects, discarding any in-flight or held fetch made stale by a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `stall_i`  in  1  hazard unit: downstream will not take the held instruction this cycle
- `branch_taken_i`  in  1  EX-stage redirect
- `branch_target_i`  in  32  branch/jump target
- `trap_i`  in  1  exception/mret redirect; has priority over branch
- `trap_target_i`  in  32  trap/return target
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  32  fetch address (= fetch PC)
- `imem_gnt_i`  in  1  request accepted this cycle
- `imem_rvalid_i`  in  1  read data valid, one cycle after gnt or later
- `imem_rdata_i`  in  32  instruction word
- `valid_o`  out  1  output register holds a live instruction
- `pc_o`  out  32  PC of held instruction
- `pc_plus_4_o`  out  32  `pc_o + 4`
- `instruction_o`  out  32  held instruction word
- `misaligned_o`  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0

## Operation
- Redirect = `trap_i | branch_taken_i`; target = trap_i ? trap_target_i : branch_target_i, with bits [1:0] forced to 0; `misaligned_o` pulses next cycle if original bits [1:0] ≠ 0.
- FSM states: S_REQ, S_WAIT, S_DROP. Reset state S_REQ.
- S_REQ: `imem_req_o = !redirect && (!valid_o || !stall_i)`. Req + gnt → S_WAIT. Redirect → fetch PC ← target, stay S_REQ.
- S_WAIT: `imem_req_o = 0`. On rvalid without redirect: `instruction_o ← rdata`, `pc_o ← fetch PC`, `pc_plus_4_o ← fetch PC+4`, `valid_o ← 1`, fetch PC ← fetch PC+4, → S_REQ. Redirect with rvalid same cycle: data discarded, fetch PC ← target, → S_REQ. Redirect without rvalid: fetch PC ← target, → S_DROP.
- S_DROP: `imem_req_o = 0`; next rvalid discarded, → S_REQ. Further redirects update fetch PC, stay S_DROP.
- Output register: consumed when `valid_o && !stall_i`; cleared on consumption unless reloaded same cycle. Redirect clears `valid_o` regardless of `stall_i` (flush beats stall).
- Request is issued only when the output slot is empty or being consumed, so rvalid always finds the slot free; no data is ever dropped without a redirect.
- Address arithmetic modulo 2^32: fetch PC 32'hFFFF_FFFC advances to 32'h0000_0000.
- `imem_req_o` held once asserted until gnt, unless a redirect arrives (then dropped for that cycle, re-asserted next cycle at new address).

## Timing
- Reset (async assert, sync-release usage): state S_REQ, fetch PC = `RESET_PC`, `valid_o`=0, `pc_o`=0, `pc_plus_4_o`=0, `instruction_o`=32'h0000_0013 (NOP), `misaligned_o`=0, `imem_req_o`=1 from first cycle after release.
- Zero-wait memory (gnt in req cycle, rvalid next cycle): req cycle N, rvalid N+1, `valid_o` high N+2, next req N+2. Throughput one instruction per 2 cycles.
- Redirect in cycle N: `valid_o`=0 in N+1; new-address req in N+1 (S_REQ) or after the stale rvalid (S_DROP).
- Reset mid-transaction: all state returns to reset values; any later rvalid for the old request must be suppressed by the memory's own reset.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory, no stall → requests at 0x0, 0x4, 0x8 every 2 cycles; outputs pc_o=0/pc_plus_4_o=4, then 4/8, instruction_o matches memory.
- stall_i high 3 cycles with valid_o=1 at pc_o=0x8 → outputs held, imem_req_o=0, resume issuing 0xC on first unstalled cycle.
- branch_taken_i, target 0x100, while in S_WAIT for 0x10 (rvalid 2 cycles later) → valid_o=0 next cycle, stale 0x10 word discarded, next req at 0x100.
- trap_i (0x200) and branch_taken_i (0x300) same cycle under stall → trap wins, valid_o cleared despite stall, next fetch 0x200.
- Branch target 0x103 → misaligned_o pulses one cycle, fetch at 0x100.
- RESET_PC=32'hFFFF_FFFC → first pc_plus_4_o=0, second fetch address 0x0.
